// File: rtl/softmax_job_ctrl.sv
// -----------------------------------------------------------------------------
// softmax_job_ctrl
// Job scheduler for one softmax engine. Descriptors from the host are buffered
// in a small FIFO; each job is run through INIT -> START -> RUN -> CMPL, the
// engine's output beats are forwarded to the output buffer while sm_done is
// high, and a one-cycle completion record (tag + error flag) is emitted.
//
// Optional feature: define SOFTMAX_JOB_TIMEOUT_EN to enable a RUN-state
// watchdog that ends a stalled job with an error after TIMEOUT_CYCLES.
// -----------------------------------------------------------------------------
module softmax_job_ctrl #(
   parameter int DATAWIDTH      = 16,
   parameter int NUM            = 4,
   parameter int ADDRSIZE       = 8,
   parameter int OADDRSIZE      = 8,
   parameter int ID_W           = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      job_valid,
   output logic                      job_ready,
   input  logic [ADDRSIZE-1:0]       job_start_addr,
   input  logic [ADDRSIZE-1:0]       job_end_addr,
   input  logic [OADDRSIZE-1:0]      job_out_base,
   input  logic [ID_W-1:0]           job_id,
   output logic                      sm_init,
   output logic                      sm_start,
   output logic [ADDRSIZE-1:0]       sm_start_addr,
   output logic [ADDRSIZE-1:0]       sm_end_addr,
   input  logic                      sm_done,
   input  logic [DATAWIDTH*NUM-1:0]  sm_outp,
   output logic                      wr_en,
   output logic [OADDRSIZE-1:0]      wr_addr,
   output logic [DATAWIDTH*NUM-1:0]  wr_data,
   output logic                      cmpl_valid,
   output logic [ID_W-1:0]           cmpl_id,
   output logic                      cmpl_err,
   output logic                      busy
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int DESC_W = 2*ADDRSIZE + OADDRSIZE + ID_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_CMPL  = 3'd4
   } state_t;

   state_t state_r;
   state_t next_state_s;

   // Descriptor FIFO
   logic [DESC_W-1:0]    fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [PTR_W-1:0]     rd_ptr_r;
   logic [PTR_W:0]       count_r;
   logic                 full_s;
   logic                 empty_s;
   logic                 push_s;
   logic                 pop_s;
   logic [DESC_W-1:0]    head_s;
   logic [ADDRSIZE-1:0]  head_start_s;
   logic [ADDRSIZE-1:0]  head_end_s;
   logic [OADDRSIZE-1:0] head_base_s;
   logic [ID_W-1:0]      head_id_s;

   // Working registers of the active job
   logic [ADDRSIZE-1:0]  cur_start_r;
   logic [ADDRSIZE-1:0]  cur_end_r;
   logic [OADDRSIZE-1:0] cur_base_r;
   logic [ID_W-1:0]      cur_id_r;
   logic [ADDRSIZE-1:0]  exp_r;
   logic [ADDRSIZE-1:0]  beat_cnt_r;
   logic                 done_prev_r;
   logic                 err_r;
   logic                 next_err_s;
   logic                 write_s;

   assign full_s    = (count_r == (PTR_W+1)'(FIFO_DEPTH));
   assign empty_s   = (count_r == {(PTR_W+1){1'b0}});
   assign job_ready = ~full_s;
   assign push_s    = job_valid & ~full_s;
   assign pop_s     = (state_r == ST_IDLE) & ~empty_s;

   assign head_s       = fifo_mem_r[rd_ptr_r];
   assign head_start_s = head_s[DESC_W-1 -: ADDRSIZE];
   assign head_end_s   = head_s[DESC_W-ADDRSIZE-1 -: ADDRSIZE];
   assign head_base_s  = head_s[ID_W +: OADDRSIZE];
   assign head_id_s    = head_s[ID_W-1:0];

   // FIFO storage write; contents need no reset because pointers gate use
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= {job_start_addr, job_end_addr, job_out_base, job_id};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

`ifdef SOFTMAX_JOB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt_r;
   logic            wd_expired_s;

   assign wd_expired_s = (wd_cnt_r >= WD_W'(TIMEOUT_CYCLES));

   // Watchdog: restarts on the way into START and on every engine beat
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else if ((state_r == ST_INIT) || sm_done) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else if ((state_r == ST_RUN) && !wd_expired_s) begin
         wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end else begin
         wd_cnt_r <= wd_cnt_r;
      end
   end
`else
   logic wd_expired_s;
   assign wd_expired_s = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state and completion status
   always_comb begin
      next_state_s = state_r;
      next_err_s   = err_r;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s) begin
               if (head_end_s <= head_start_s) begin
                  next_state_s = ST_CMPL;
                  next_err_s   = 1'b1;
               end else begin
                  next_state_s = ST_INIT;
                  next_err_s   = 1'b0;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_INIT:  next_state_s = ST_START;
         ST_START: next_state_s = ST_RUN;
         ST_RUN: begin
            if (sm_done && (beat_cnt_r == exp_r - ADDRSIZE'(1))) begin
               next_state_s = ST_CMPL;
               next_err_s   = 1'b0;
            end else if (done_prev_r && !sm_done) begin
               // engine stopped producing before the job was complete
               next_state_s = ST_CMPL;
               next_err_s   = 1'b1;
            end else if (wd_expired_s) begin
               next_state_s = ST_CMPL;
               next_err_s   = 1'b1;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_CMPL:  next_state_s = ST_IDLE;
         default:  next_state_s = ST_IDLE;
      endcase
   end

   // Job working registers, beat counter and done history
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_start_r <= {ADDRSIZE{1'b0}};
         cur_end_r   <= {ADDRSIZE{1'b0}};
         cur_base_r  <= {OADDRSIZE{1'b0}};
         cur_id_r    <= {ID_W{1'b0}};
         exp_r       <= {ADDRSIZE{1'b0}};
         beat_cnt_r  <= {ADDRSIZE{1'b0}};
         done_prev_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         if (pop_s) begin
            cur_start_r <= head_start_s;
            cur_end_r   <= head_end_s;
            cur_base_r  <= head_base_s;
            cur_id_r    <= head_id_s;
            exp_r       <= head_end_s - head_start_s;
         end
         if (state_r == ST_START) begin
            beat_cnt_r  <= {ADDRSIZE{1'b0}};
            done_prev_r <= 1'b0;
         end else if (state_r == ST_RUN) begin
            if (sm_done) begin
               beat_cnt_r <= beat_cnt_r + ADDRSIZE'(1);
            end
            done_prev_r <= sm_done;
         end else begin
            beat_cnt_r  <= beat_cnt_r;
            done_prev_r <= done_prev_r;
         end
         err_r <= next_err_s;
      end
   end

   assign sm_start_addr = cur_start_r;
   assign sm_end_addr   = cur_end_r;
   assign busy          = (state_r != ST_IDLE) | ~empty_s;

   // FSM output decode; writes pass through combinationally during RUN
   always_comb begin
      sm_init    = (state_r == ST_INIT);
      sm_start   = (state_r == ST_START);
      write_s    = (state_r == ST_RUN) && sm_done;
      wr_en      = write_s;
      cmpl_valid = (state_r == ST_CMPL);
      if (write_s) begin
         wr_addr = cur_base_r + OADDRSIZE'(beat_cnt_r);
         wr_data = sm_outp;
      end else begin
         wr_addr = {OADDRSIZE{1'b0}};
         wr_data = {(DATAWIDTH*NUM){1'b0}};
      end
      if (state_r == ST_CMPL) begin
         cmpl_id  = cur_id_r;
         cmpl_err = err_r;
      end else begin
         cmpl_id  = {ID_W{1'b0}};
         cmpl_err = 1'b0;
      end
   end

endmodule

// File: tb/tb_softmax_job_ctrl.sv
// -----------------------------------------------------------------------------
// tb_softmax_job_ctrl
// Scoreboard bench: a host driver and an engine model push expected writes,
// start addresses and completions into queues; an independent monitor pops
// and compares whenever the DUT presents the corresponding output.
// -----------------------------------------------------------------------------
module tb_softmax_job_ctrl;

   localparam int DW = 16;
   localparam int NN = 4;
   localparam int AW = 8;
   localparam int OW = 8;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            job_valid = 1'b0;
   logic            job_ready;
   logic [AW-1:0]   job_start_addr = '0;
   logic [AW-1:0]   job_end_addr = '0;
   logic [OW-1:0]   job_out_base = '0;
   logic [IW-1:0]   job_id = '0;
   logic            sm_init, sm_start;
   logic [AW-1:0]   sm_start_addr, sm_end_addr;
   logic            sm_done = 1'b0;
   logic [DW*NN-1:0] sm_outp = '0;
   logic            wr_en;
   logic [OW-1:0]   wr_addr;
   logic [DW*NN-1:0] wr_data;
   logic            cmpl_valid;
   logic [IW-1:0]   cmpl_id;
   logic            cmpl_err;
   logic            busy;

   softmax_job_ctrl #(
      .DATAWIDTH(DW), .NUM(NN), .ADDRSIZE(AW), .OADDRSIZE(OW),
      .ID_W(IW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(1024)
   ) dut (
      .clk(clk), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_start_addr(job_start_addr), .job_end_addr(job_end_addr),
      .job_out_base(job_out_base), .job_id(job_id),
      .sm_init(sm_init), .sm_start(sm_start),
      .sm_start_addr(sm_start_addr), .sm_end_addr(sm_end_addr),
      .sm_done(sm_done), .sm_outp(sm_outp),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id), .cmpl_err(cmpl_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] s;
      logic [7:0] e;
      logic [7:0] base;
      int         exp;
      int         k;
      int         dly;
   } job_t;
   typedef struct { logic [3:0] id; logic err; } cmpl_t;
   typedef struct { logic [7:0] addr; logic [63:0] data; } wr_t;

   job_t  eng_q[$];
   job_t  init_q[$];
   cmpl_t cmpl_q[$];
   wr_t   wr_q[$];

   int errors = 0;
   int checks = 0;
   bit abort = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic fail_event(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got an event, required none", name);
   endtask

   // Monitor: compares DUT outputs against the queued expectations
   initial begin
      cmpl_t c;
      wr_t   w;
      job_t  j;
      forever begin
         @(negedge clk);
         #2;
         if (reset) continue;
         check("init_start_overlap", {63'd0, sm_init & sm_start}, 64'd0);
         if (sm_init) begin
            if (init_q.size() == 0) fail_event("unexpected_sm_init");
            else begin
               j = init_q.pop_front();
               check("sm_start_addr", {56'd0, sm_start_addr}, {56'd0, j.s});
               check("sm_end_addr", {56'd0, sm_end_addr}, {56'd0, j.e});
            end
         end
         if (wr_en) begin
            if (wr_q.size() == 0) fail_event("unexpected_write");
            else begin
               w = wr_q.pop_front();
               check("wr_addr", {56'd0, wr_addr}, {56'd0, w.addr});
               check("wr_data", wr_data, w.data);
            end
         end
         if (cmpl_valid) begin
            if (cmpl_q.size() == 0) fail_event("unexpected_cmpl");
            else begin
               c = cmpl_q.pop_front();
               check("cmpl_id", {60'd0, cmpl_id}, {60'd0, c.id});
               check("cmpl_err", {63'd0, cmpl_err}, {63'd0, c.err});
            end
         end
      end
   end

   // Engine model: after sm_start, waits dly cycles then produces k beats
   initial begin
      job_t       j;
      wr_t        w;
      logic [63:0] d;
      forever begin
         @(negedge clk);
         if (sm_start === 1'b1 && !reset && !abort) begin
            if (eng_q.size() == 0) fail_event("unexpected_sm_start");
            else begin
               j = eng_q.pop_front();
               repeat (j.dly) @(negedge clk);
               for (int b = 0; b < j.k; b++) begin
                  if (abort) break;
                  d = {$urandom(), $urandom()};
                  sm_outp = d;
                  sm_done = 1'b1;
                  if (b < j.exp) begin
                     w.addr = j.base + 8'(b);
                     w.data = d;
                     wr_q.push_back(w);
                  end
                  @(negedge clk);
               end
               sm_done = 1'b0;
               sm_outp = '0;
            end
         end
      end
   end

   // Host driver: offers a descriptor at a negedge and records it on acceptance
   task automatic push_job(input logic [7:0] s, input logic [7:0] e, input logic [7:0] base,
                           input logic [3:0] id, input int k, input int dly);
      int    cnt;
      job_t  j;
      cmpl_t c;
      job_valid      = 1'b1;
      job_start_addr = s;
      job_end_addr   = e;
      job_out_base   = base;
      job_id         = id;
      cnt = 0;
      while (job_ready !== 1'b1 && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 2000) begin
         fail_event("job_ready_timeout");
      end else begin
         j.s = s; j.e = e; j.base = base; j.k = k; j.dly = dly;
         j.exp = (int'(e) > int'(s)) ? int'(e) - int'(s) : 0;
         c.id  = id;
         c.err = (j.exp == 0) || (k < j.exp);
         cmpl_q.push_back(c);
         if (j.exp > 0) begin
            init_q.push_back(j);
            eng_q.push_back(j);
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int cnt;
      cnt = 0;
      while ((busy !== 1'b0 || cmpl_q.size() != 0 || wr_q.size() != 0 || sm_done) && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 3000) fail_event("idle_timeout");
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int s, d, k, ex;
      repeat (3) @(negedge clk);
      #2;
      check("reset_ctrl_outs", {58'd0, sm_init, sm_start, wr_en, cmpl_valid, cmpl_err, busy}, 64'd0);
      check("reset_addr_outs", {40'd0, sm_start_addr, sm_end_addr, wr_addr}, 64'd0);
      check("reset_cmpl_id", {60'd0, cmpl_id}, 64'd0);
      check("reset_job_ready", {63'd0, job_ready}, 64'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // single job, latency to sm_init
      push_job(8'd0, 8'd4, 8'h10, 4'd3, 4, 1);
      job_valid = 1'b0;
      #2;
      check("init_not_early", {63'd0, sm_init}, 64'd0);
      @(negedge clk);
      #2;
      check("init_latency", {63'd0, sm_init}, 64'd1);
      wait_idle();

      // empty descriptor: error completion two cycles after acceptance
      push_job(8'd5, 8'd5, 8'h20, 4'd7, 1, 1);
      job_valid = 1'b0;
      @(negedge clk);
      #2;
      check("zero_len_cmpl", {62'd0, cmpl_valid, cmpl_err}, 64'd3);
      wait_idle();

      // early drop, then a normal job; wrap; extra beat discarded
      push_job(8'd0, 8'd4, 8'h30, 4'd2, 2, 2);
      push_job(8'd8, 8'd10, 8'h40, 4'd4, 2, 1);
      job_valid = 1'b0;
      wait_idle();
      push_job(8'h10, 8'h14, 8'hFE, 4'd5, 4, 1);
      push_job(8'd0, 8'd3, 8'h50, 4'd6, 4, 3);
      job_valid = 1'b0;
      wait_idle();

      // FIFO full while a slow job runs
      push_job(8'd0, 8'd2, 8'h00, 4'd0, 2, 25);
      for (int i = 1; i <= 4; i++) push_job(8'd0, 8'd2, 8'(8 * i), 4'(i), 2, 1);
      check("fifo_full_ready", {63'd0, job_ready}, 64'd0);
      check("fifo_full_busy", {63'd0, busy}, 64'd1);
      push_job(8'd0, 8'd2, 8'h60, 4'd5, 2, 1);
      job_valid = 1'b0;
      wait_idle();

      // randomized jobs
      for (int n = 0; n < 30; n++) begin
         s  = $urandom_range(240, 2);
         d  = $urandom_range(9, 0);
         ex = (d > 2) ? d - 2 : 0;
         case ($urandom_range(3, 0))
            0:       k = (ex > 1) ? $urandom_range(ex - 1, 1) : 1;
            1:       k = ex + 1;
            default: k = (ex > 0) ? ex : 1;
         endcase
         push_job(8'(s), 8'(s + d - 2), 8'($urandom_range(255, 0)), 4'($urandom_range(15, 0)),
                  k, $urandom_range(3, 1));
         job_valid = 1'b0;
         repeat ($urandom_range(2, 0)) @(negedge clk);
      end
      wait_idle();

      // reset during RUN aborts the job without completion
      push_job(8'd0, 8'd6, 8'h70, 4'd9, 6, 10);
      job_valid = 1'b0;
      k = 0;
      while (sm_start !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) fail_event("sm_start_timeout");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      abort = 1'b1;
      cmpl_q.delete();
      init_q.delete();
      eng_q.delete();
      wr_q.delete();
      @(negedge clk);
      #2;
      check("midrun_reset_outs", {58'd0, sm_init, sm_start, wr_en, cmpl_valid, cmpl_err, busy}, 64'd0);
      check("midrun_reset_addrs", {40'd0, sm_start_addr, sm_end_addr, wr_addr}, 64'd0);
      check("midrun_reset_ready", {63'd0, job_ready}, 64'd1);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      check("drain_cmpl_q", 64'(cmpl_q.size()), 64'd0);
      check("drain_wr_q", 64'(wr_q.size()), 64'd0);
      check("drain_init_q", 64'(init_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
